// File: rtl/tomasulo_rs.sv
// Reservation station: holds issued ops, snoops the CDB, dispatches oldest ready entry to one FU.
// Ready/bypassed issue dispatches the next cycle; a dispatch held by fu_ready low stays locked.
module tomasulo_rs #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int OP_W    = 2,
  parameter int RS_BASE = 0
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [OP_W-1:0]        issue_op,
  input  logic                   issue_j_pend,
  input  logic                   issue_k_pend,
  input  logic [DATA_W-1:0]      issue_vj,
  input  logic [DATA_W-1:0]      issue_vk,
  input  logic [TAG_W-1:0]       issue_qj,
  input  logic [TAG_W-1:0]       issue_qk,
  output logic [TAG_W-1:0]       issue_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [DATA_W-1:0]      cdb_data,
  output logic                   fu_valid,
  input  logic                   fu_ready,
  output logic [OP_W-1:0]        fu_op,
  output logic [DATA_W-1:0]      fu_a,
  output logic [DATA_W-1:0]      fu_b,
  output logic [TAG_W-1:0]       fu_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [TAG_W-1:0] BASE_TAG = TAG_W'(RS_BASE);

  logic [DEPTH-1:0]  busy, j_pend, k_pend;
  logic [OP_W-1:0]   op_q [DEPTH];
  logic [DATA_W-1:0] vj_q [DEPTH];
  logic [DATA_W-1:0] vk_q [DEPTH];
  logic [TAG_W-1:0]  qj_q [DEPTH];
  logic [TAG_W-1:0]  qk_q [DEPTH];
  // Age = number of busy entries issued before this one; always 0..count-1 and unique.
  logic [IDX_W-1:0]  age  [DEPTH];
  logic              lock_vld;
  logic [IDX_W-1:0]  lock_idx;

  logic              free_vld, rdy_vld, sel_vld;
  logic [IDX_W-1:0]  free_idx, rdy_idx, sel_idx, best_age, disp_age, new_age;
  logic              do_issue, do_disp, byp_j, byp_k;

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rdy_vld  = 1'b0;
    rdy_idx  = '0;
    best_age = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i] && !j_pend[i] && !k_pend[i] && (!rdy_vld || age[i] < best_age)) begin
        rdy_vld  = 1'b1;
        rdy_idx  = IDX_W'(i);
        best_age = age[i];
      end
    end
  end

  assign sel_vld     = lock_vld | rdy_vld;
  assign sel_idx     = lock_vld ? lock_idx : rdy_idx;
  assign fu_valid    = sel_vld && !flush;
  assign fu_op       = sel_vld ? op_q[sel_idx] : '0;
  assign fu_a        = sel_vld ? vj_q[sel_idx] : '0;
  assign fu_b        = sel_vld ? vk_q[sel_idx] : '0;
  assign fu_tag      = sel_vld ? BASE_TAG + TAG_W'(sel_idx) : '0;

  assign issue_ready = free_vld && !flush;
  assign issue_tag   = BASE_TAG + TAG_W'(free_idx);
  assign do_issue    = issue_valid && issue_ready;
  assign do_disp     = fu_valid && fu_ready;
  assign disp_age    = age[sel_idx];
  // Issue only happens when not full, so count fits in an age after a same-cycle dispatch.
  assign new_age     = IDX_W'(count - CNT_W'(do_disp));
  assign byp_j       = cdb_valid && issue_j_pend && (issue_qj == cdb_tag);
  assign byp_k       = cdb_valid && issue_k_pend && (issue_qk == cdb_tag);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      j_pend   <= '0;
      k_pend   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
        age[i]  <= '0;
      end
    end else if (flush) begin
      busy     <= '0;
      lock_vld <= 1'b0;
      count    <= '0;
    end else begin
      count <= count + CNT_W'(do_issue) - CNT_W'(do_disp);
      if (do_disp) begin
        lock_vld <= 1'b0;
      end else if (fu_valid) begin
        lock_vld <= 1'b1;
        lock_idx <= sel_idx;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          if (cdb_valid && j_pend[i] && (qj_q[i] == cdb_tag)) begin
            vj_q[i]   <= cdb_data;
            j_pend[i] <= 1'b0;
          end
          if (cdb_valid && k_pend[i] && (qk_q[i] == cdb_tag)) begin
            vk_q[i]   <= cdb_data;
            k_pend[i] <= 1'b0;
          end
          if (do_disp && (sel_idx == IDX_W'(i))) begin
            busy[i] <= 1'b0;
          end else if (do_disp && (age[i] > disp_age)) begin
            age[i] <= age[i] - IDX_W'(1);
          end
        end else if (do_issue && (free_idx == IDX_W'(i))) begin
          busy[i]   <= 1'b1;
          op_q[i]   <= issue_op;
          vj_q[i]   <= byp_j ? cdb_data : issue_vj;
          vk_q[i]   <= byp_k ? cdb_data : issue_vk;
          qj_q[i]   <= issue_qj;
          qk_q[i]   <= issue_qk;
          j_pend[i] <= issue_j_pend && !byp_j;
          k_pend[i] <= issue_k_pend && !byp_k;
          age[i]    <= new_age;
        end
      end
    end
  end

endmodule
